// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with show-ahead receive FIFO; parity framing enabled by UART_RX_PARITY_EN
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 286,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   tick;
    logic                   push;

    logic [AW:0]            wptr;
    logic [AW:0]            rptr;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic                   full;
    logic                   pop;
    logic                   wr;

    // Bring the asynchronous line into the clk domain; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The bit-period counter runs down; a sample is taken when it reaches zero.
    assign tick = (cnt == '0);

    // A good frame is handed to the FIFO on the stop-sample edge itself.
    assign push = (state == S_STOP) && tick && rx_s && !par_bad;

    // Frame receiver: start qualification, data shift, optional parity, stop check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= CW'(HALF - 1);
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            cnt     <= CW'(CLKS_PER_BIT - 1);
                            bit_idx <= BW'(DATA_BITS - 1);
                            state   <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        if (bit_idx == '0) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD[0];
                        cnt     <= CW'(CLKS_PER_BIT - 1);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign count    = wptr - rptr;
    assign rd_valid = (wptr != rptr);
    assign full     = (count == FIFO_DEPTH[AW:0]);
    assign pop      = rd_en && rd_valid;
    assign wr       = push && (!full || pop);
    assign rd_data  = rd_valid ? mem[rptr[AW-1:0]] : '0;

    // Pointer bookkeeping and overrun reporting; the extra MSB tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage array; a full push-with-pop overwrites the slot being popped.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= shreg;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a receive FIFO, clocked from the LPC clock domain. It is the next generation of the receive path behind the LPC UART bridge. Bit period, data width and FIFO depth are parameters, and framing, parity and overrun errors are reported. The LPC register front end drains it through a show-ahead read port.

## Interface
Parameters:
- CLKS_PER_BIT, 286, clock cycles per UART bit (286 = 33 MHz / 115200); minimum 4
- DATA_BITS, 8, data bits per frame, 5..8
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when parity is compiled in
- FIFO_DEPTH, 16, receive FIFO entries, power of two, 2..256

Ports:
- clk  in  1  LPC clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx  in  1  serial input, idle high, asynchronous to clk
- rd_en  in  1  pop the head entry; ignored while rd_valid = 0
- rd_data  out  DATA_BITS  head entry (show-ahead); valid while rd_valid = 1
- rd_valid  out  1  FIFO not empty
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch (constant 0 without parity)
- overrun  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full

## Operation
- rx passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
- FSM states and behaviour:
  - IDLE: a falling edge on rx_s loads the bit counter and enters START.
  - START: samples rx_s at HALF = CLKS_PER_BIT/2 (integer divide). If the sample is 1, it is treated as a glitch and the FSM returns to IDLE with no error. If 0, the FSM enters DATA.
  - DATA: takes DATA_BITS samples, one every CLKS_PER_BIT cycles, LSB first, shifted into the data register. It then enters PARITY if parity is compiled in, else STOP.
  - PARITY: takes one sample and compares it with the XOR of the data bits (XNOR when PARITY_ODD = 1).
  - STOP: takes one sample.
    - If 1 and there was no parity error, the byte is pushed.
    - If 1 with a parity error, parity_err pulses and the byte is discarded.
    - If 0, frame_err pulses and the byte is discarded. The FSM then enters BREAK.
    - Otherwise the FSM enters IDLE.
  - BREAK: waits for rx_s = 1, then enters IDLE. This prevents a held-low line from retriggering.
- A parity error together with a low stop bit pulses frame_err only.
- FIFO:
  - Circular buffer with write/read pointers of $clog2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2·FIFO_DEPTH.
  - Push when full and no pop: byte dropped, overrun pulses, contents unchanged.
  - Push and pop in the same cycle when full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle when empty: only the push happens (rd_en is ignored because rd_valid = 0).
  - rd_en while empty: no effect; count never underflows.

## Timing
- Reset values:
  - FSM in IDLE; both synchronizer flops at 1.
  - Pointers at 0; count = 0; rd_valid = 0.
  - rd_data = 0.
  - frame_err, parity_err and overrun all 0.
- Cycle 0 is the cycle the falling edge is seen on rx_s (2 cycles after the rx pin falls).
- Bit sample times:
  - Start-bit sample at cycle HALF.
  - Bit k (start = 0) sampled at HALF + k·CLKS_PER_BIT.
  - Stop-bit sample at HALF + (DATA_BITS + P + 1)·CLKS_PER_BIT, where P = 1 with parity, else 0.
- The push registers on the stop-sample edge. rd_valid, rd_data and count update on the next cycle.
  - 8N1 at 286: first rd_valid at cycle 2718.
- The error pulses assert on the cycle after the stop sample, for exactly 1 cycle.
- After the stop sample the FSM is in IDLE (or BREAK). A start edge is accepted from the following cycle.
- Pop: rd_en = 1 at edge N. The next entry appears on rd_data, and count decrements, after edge N.
- Reset mid-frame: the frame is aborted and the FIFO emptied asynchronously. No pulses occur. After release, the first falling edge starts a new frame.

## Configuration
- UART_RX_PARITY_EN
  - Defined: the PARITY state exists, frames carry one parity bit, and parity_err is live.
  - Undefined: no parity bit is expected (stop sampled at bit DATA_BITS+1), parity_err is tied 0, and PARITY_ODD is ignored.

## Test plan
- Reset, idle 10 cycles; send 0x0f then 0xa5 (8N1, 286 cycles/bit), no reads -> count = 2; rd_data = 0x0f; rd_en -> rd_data = 0xa5; rd_en -> rd_valid = 0, count = 0.
- Low pulse on rx of 100 cycles, then idle 1000 cycles -> no push, no error pulses, FSM back in IDLE; then send 0xf0 -> rd_data = 0xf0.
- Send 0x55 with stop bit driven 0, line held low 2000 cycles, then high -> one frame_err pulse, count = 0, no second frame; then send 0x33 -> received correctly.
- Send 17 bytes 0x00..0x10 without reads -> count = 16, one overrun pulse on byte 0x10; reads return 0x00..0x0f, then rd_valid = 0. Repeat with rd_en asserted in the 0x10 push cycle -> no overrun.
- With UART_RX_PARITY_EN, PARITY_ODD = 0: send 0x07 with parity bit 1 -> pushed; send 0x07 with parity bit 0 -> parity_err pulse, not pushed.
- Assert rst during data bit 4 of 0xa5 while the FIFO holds 3 bytes -> count = 0 and rd_valid = 0 immediately; after release, send 0x0f -> count = 1, rd_data = 0x0f.
